dout_dwell: RTL

DOUT_DWELL -- requirements
Module: dout_dwell

---
 rtl/dout_dwell_pkg.sv | 22 ++
 rtl/sat_cnt16.sv | 32 +++
 rtl/dout_dwell.sv | 104 ++++++++++
 3 files changed

// File: rtl/dout_dwell_pkg.sv
// Shared definitions for the output dwell shaper and the input shake filter.
// Holds the 16-bit counter width and saturation constant, and the per-level
// FSM state encoding (bit 0 = held level, bit 1 = dwell still running).
package dout_dwell_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        SETTLED_LO = 2'b00,
        SETTLED_HI = 2'b01,
        DWELL_LO   = 2'b10,
        DWELL_HI   = 2'b11
    } dwell_state_t;

    // Build the state for a held level, flagging whether its dwell is still running.
    function automatic dwell_state_t state_for(input logic level, input logic dwelling);
        return dwell_state_t'({dwelling, level});
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit saturating up-counter with synchronous load.
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset, loads RST_VAL
//   load     synchronous load of load_val (priority over inc)
//   load_val value taken on load
//   inc      increment by one, holding at CNT_MAX
//   count    current count
module sat_cnt16
    import dout_dwell_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/dout_dwell.sv
// Output dwell shaper: data_o follows data_i one cycle later, except that a
// level must be held for its minimum dwell (min_hi_i / min_lo_i cycles) before
// it may change. Requests withdrawn while held off are counted in drop_cnt_o.
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_n_i     asynchronous active-low reset
//   data_i      requested output level
//   min_hi_i    minimum high dwell in cycles (0/1 = unconstrained)
//   min_lo_i    minimum low dwell in cycles (0/1 = unconstrained)
//   clr_i       synchronous clear of drop_cnt_o
//   data_o      shaped output level, registered
//   busy_o      current level's dwell not yet met
//   pend_o      a level change is being held off
//   drop_cnt_o  saturating count of withdrawn requests
module dout_dwell
    import dout_dwell_pkg::*;
#(
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             data_i,
    input  logic [CNT_W-1:0] min_hi_i,
    input  logic [CNT_W-1:0] min_lo_i,
    input  logic             clr_i,
    output logic             data_o,
    output logic             busy_o,
    output logic             pend_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam dwell_state_t RST_STATE = state_for(INIT_LEVEL, 1'b0);

    dwell_state_t     state;
    dwell_state_t     state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] min_cur;
    logic [CNT_W-1:0] min_new;
    logic             met;
    logic             differs;
    logic             toggle;
    logic             pend_q;
    logic             drop_evt;

    // The output level is bit 0 of the state register, so data_o is a flop.
    assign data_o = state[0];

    always_comb begin
        min_cur  = data_o ? min_hi_i : min_lo_i;
        met      = (hold_cnt >= min_cur);
        differs  = (data_i != data_o);
        toggle   = met && differs;
        busy_o   = !met;
        pend_o   = !met && differs;
        // A request held off last cycle has been withdrawn while still held off.
        drop_evt = pend_q && !differs && !met;
    end

    always_comb begin
        state_nxt = state;
        min_new   = data_i ? min_hi_i : min_lo_i;
        if (toggle) begin
            // Counter restarts at 1, so the new level is settled at once if its min <= 1.
            state_nxt = state_for(data_i, min_new > CNT_ONE);
        end else begin
            state_nxt = state_for(data_o, !met);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= RST_STATE;
            pend_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend_q <= pend_o;
        end
    end

    // Dwell age: reset to "met" so the first edge after reset may toggle.
    sat_cnt16 #(
        .RST_VAL (CNT_MAX)
    ) u_hold_cnt (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .load     (toggle),
        .load_val (CNT_ONE),
        .inc      (1'b1),
        .count    (hold_cnt)
    );

    // Clear loads zero and therefore wins over a drop on the same edge.
    sat_cnt16 #(
        .RST_VAL ('0)
    ) u_drop_cnt (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .load     (clr_i),
        .load_val ('0),
        .inc      (drop_evt),
        .count    (drop_cnt_o)
    );

endmodule
